// File: rtl/segment_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Digits and leading-zero blank flags stay registered and only update on the done edge.
module segment_bcd_converter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_0,
  output logic [3:0]       bcd_1,
  output logic [3:0]       bcd_2,
  output logic [3:0]       bcd_3,
  output logic [3:0]       bcd_4,
  output logic [3:0]       bcd_5,
  output logic [3:0]       bcd_6,
  output logic [3:0]       bcd_7,
  output logic [7:0]       blank
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [31:0]      r_work;
  logic [31:0]      r_bcd;
  logic [4:0]       r_count;
  logic [7:0]       r_blank;
  logic             r_busy;
  logic             r_done;

  logic [31:0]         w_adj;
  logic [31+WIDTH:0]   w_shifted;
  logic [7:0]          w_blank;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < 8; i++) begin
      w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ? r_work[4*i +: 4] + 4'd3
                                                   : r_work[4*i +: 4];
    end
    w_shifted = {w_adj, r_shift} << 1;
  end

  // Leading-zero flags from the post-iteration digits; digit 0 never blanks.
  always_comb begin
    logic upperZero;
    w_blank   = '0;
    upperZero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      upperZero  = upperZero && (w_shifted[WIDTH + 4*i +: 4] == 4'd0);
      w_blank[i] = upperZero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_work  <= '0;
      r_bcd   <= '0;
      r_count <= '0;
      r_blank <= 8'hFE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= bin_in;
            r_work  <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work  <= w_shifted[31+WIDTH:WIDTH];
          r_shift <= w_shifted[WIDTH-1:0];
          r_count <= r_count + 5'd1;
          if (r_count == LAST) begin
            r_bcd   <= w_shifted[31+WIDTH:WIDTH];
            r_blank <= w_blank;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign blank = r_blank;
  assign bcd_0 = r_bcd[3:0];
  assign bcd_1 = r_bcd[7:4];
  assign bcd_2 = r_bcd[11:8];
  assign bcd_3 = r_bcd[15:12];
  assign bcd_4 = r_bcd[19:16];
  assign bcd_5 = r_bcd[23:20];
  assign bcd_6 = r_bcd[27:24];
  assign bcd_7 = r_bcd[31:28];

endmodule

// File: tb/tb_segment_bcd_converter.sv
// Self-checking bench for segment_bcd_converter; expected digits come from
// decimal arithmetic on the converted value, not from the shift-add algorithm.
module tb_segment_bcd_converter;

  localparam int WIDTH = 10;

  logic             clk;
  logic             rstb;
  logic             start;
  logic [WIDTH-1:0] binIn;
  logic             busy;
  logic             done;
  logic [3:0]       bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7;
  logic [7:0]       blank;

  int errors = 0;
  int checks = 0;
  int unsigned lastVal = 0;
  int unsigned pending = 0;

  segment_bcd_converter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .start (start),
    .bin_in(binIn),
    .busy  (busy),
    .done  (done),
    .bcd_0 (bcd0),
    .bcd_1 (bcd1),
    .bcd_2 (bcd2),
    .bcd_3 (bcd3),
    .bcd_4 (bcd4),
    .bcd_5 (bcd5),
    .bcd_6 (bcd6),
    .bcd_7 (bcd7),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare every output against the decimal expansion of val.
  task automatic checkOutput(input string tag, input int unsigned val,
                             input logic expBusy, input logic expDone);
    logic [3:0]  expDig [8];
    logic [3:0]  gotDig [8];
    logic [7:0]  expBlank;
    int unsigned t;
    bit          seenNonZero;
    t = val;
    for (int i = 0; i < 8; i++) begin
      expDig[i] = 4'(t % 10);
      t = t / 10;
    end
    expBlank    = 8'h00;
    seenNonZero = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (expDig[i] != 4'd0) seenNonZero = 1'b1;
      expBlank[i] = !seenNonZero;
    end
    gotDig[0] = bcd0; gotDig[1] = bcd1; gotDig[2] = bcd2; gotDig[3] = bcd3;
    gotDig[4] = bcd4; gotDig[5] = bcd5; gotDig[6] = bcd6; gotDig[7] = bcd7;

    checks++;
    assert (busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s busy got %b want %b", tag, busy, expBusy);
    end
    checks++;
    assert (done === expDone) else begin
      errors++;
      $error("[TB] FAIL %s done got %b want %b", tag, done, expDone);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      assert (gotDig[i] === expDig[i]) else begin
        errors++;
        $error("[TB] FAIL %s bcd_%0d got %0d want %0d (value %0d)",
               tag, i, gotDig[i], expDig[i], val);
      end
    end
    checks++;
    assert (blank === expBlank) else begin
      errors++;
      $error("[TB] FAIL %s blank got %h want %h (value %0d)", tag, blank, expBlank, val);
    end
  endtask

  // Full conversion from idle; random start/bin_in noise while busy must be ignored.
  task automatic applyStimulus(input string tag, input int unsigned v);
    start = 1'b1;
    binIn = WIDTH'(v);
    @(negedge clk);
    for (int n = 1; n <= WIDTH; n++) begin
      checkOutput({tag, "_busy"}, lastVal, 1'b1, 1'b0);
      start = 1'($urandom_range(0, 1));
      binIn = WIDTH'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, "_done"}, v, 1'b0, 1'b1);
    lastVal = v;
  endtask

  initial begin
    rstb  = 1'b0;
    start = 1'b0;
    binIn = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 0, 1'b0, 1'b0);
    rstb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("idle", 0, 1'b0, 1'b0);
    end

    applyStimulus("v1023", 1023);
    @(negedge clk);
    checkOutput("hold1023", 1023, 1'b0, 1'b0);
    applyStimulus("v9", 9);
    @(negedge clk);
    applyStimulus("v10", 10);
    @(negedge clk);
    applyStimulus("v599", 599);
    @(negedge clk);
    applyStimulus("v0", 0);
    @(negedge clk);
    checkOutput("hold0", 0, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      applyStimulus("rand", $urandom_range(0, (1 << WIDTH) - 1));
      @(negedge clk);
    end

    // Back-to-back: new start accepted in the done cycle of the previous one.
    applyStimulus("b2b1000", 1000);
    start = 1'b1;
    binIn = WIDTH'(500);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= WIDTH; n++) begin
      checkOutput("b2b_busy", 1000, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("b2b_done500", 500, 1'b0, 1'b1);
    lastVal = 500;
    @(negedge clk);

    // Start held high; only bin_in on accept edges matters.
    start   = 1'b1;
    binIn   = WIDTH'($urandom);
    pending = int'(binIn);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      for (int n = 1; n <= WIDTH; n++) begin
        checkOutput("cont_busy", lastVal, 1'b1, 1'b0);
        binIn = WIDTH'($urandom);
        @(negedge clk);
      end
      checkOutput("cont_done", pending, 1'b0, 1'b1);
      lastVal = pending;
      if (c < 3) begin
        binIn   = WIDTH'($urandom);
        pending = int'(binIn);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("cont_idle", lastVal, 1'b0, 1'b0);

    // Reset in the middle of a conversion aborts it without a done pulse.
    applyStimulus("pre1000", 1000);
    @(negedge clk);
    start = 1'b1;
    binIn = WIDTH'(77);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      checkOutput("abort_busy", 1000, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("abort_busy4", 1000, 1'b1, 1'b0);
    rstb = 1'b0;
    @(negedge clk);
    checkOutput("abort_rst", 0, 1'b0, 1'b0);
    lastVal = 0;
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("abort_nodone", 0, 1'b0, 1'b0);
    end
    applyStimulus("v77", 77);
    @(negedge clk);
    checkOutput("hold77", 77, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/segment_bcd_converter.md
Name: segment_bcd_converter

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm.
Sits directly upstream of the 7-segment digit memory/decoder stage. Turns a binary count (e.g. the 10-bit row counter) into eight BCD nibbles plus leading-zero blank flags.
Start/busy/done handshake. Results stay registered and stable between conversions, so the downstream decoders never see partial values.

Parameters:
WIDTH, 10, bit width of binary input; legal range 1..26 (guarantees 2^WIDTH < 10^8, so no overflow).

Ports:
clk  input  1  system clock, all logic on rising edge
rstb  input  1  synchronous active-low reset
start  input  1  conversion request; sampled only when busy=0
bin_in  input  WIDTH  binary value; captured on the edge where start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse when new results are valid
bcd_0..bcd_7  output  4 each  BCD digits; bcd_0 = units, bcd_7 = 10^7
blank  output  8  blank[i]=1 when digit i is a leading zero; blank[0] is always 0

Behaviour:
- Reset: synchronous, active-low; rstb=0 at a rising edge is the only reset condition. When applied:
  - state=IDLE; busy=0; done=0.
  - All bcd_i=0; blank=8'hFE.
  - Internal shift register, BCD working register and counter cleared.
  - Reset during a conversion aborts it; no done pulse is produced for the aborted request.
- States:
  - IDLE:
    - start=1 at edge E0: load shift register<=bin_in, working BCD<=0, counter<=0; go to SHIFT; busy=1 after E0.
    - start=0: remain in IDLE.
  - SHIFT, one iteration per cycle:
    - (a) every working nibble >=5 gets +3 (4-bit add, no carry out; value <=12);
    - (b) shift the {working BCD, shift register} concatenation left by 1;
    - counter increments.
    - When counter reaches WIDTH-1 at an edge, that edge performs the final iteration, and:
      - writes the post-iteration working BCD to bcd_0..bcd_7;
      - computes blank;
      - asserts done=1 and busy=0;
      - returns to IDLE.
- Latency and throughput:
  - The start edge is E0; shifts occur at E1..E_WIDTH; results and done appear after edge E_WIDTH.
  - done is high for exactly 1 cycle.
  - Throughput is one conversion per WIDTH+1 cycles.
- Handshake:
  - start while busy=1 is ignored: neither queued nor affecting the current conversion.
  - start in the same cycle that done=1 is accepted, because state is already IDLE.
  - bin_in changes after the accept edge have no effect.
- Output stability:
  - bcd_i and blank hold their previous values throughout SHIFT.
  - They change only on the done edge or on reset.
- blank rule:
  - blank[i]=1 iff bcd_i==0 and all bcd_j==0 for j>i, for i=1..7.
  - blank[0]=0 always, so the value 0 displays as a single "0".
  - blank is registered together with the digits.
- WIDTH=1 is legal: one shift cycle; done after E1.

Test Plan:
- Reset then idle: rstb=0 for 2 cycles, release, no start -> busy=0, done=0, all bcd=0, blank=8'hFE, held indefinitely.
- bin_in=1023, start 1 cycle -> busy for 10 cycles; done pulse after the 10th shift edge; bcd_3..0 = 1,0,2,3; bcd_7..4=0; blank=8'hF0.
- Adjust boundaries:
  - bin_in=9 -> bcd_0=9, blank=8'hFE.
  - bin_in=10 -> bcd_1=1, bcd_0=0, blank=8'hFC.
  - bin_in=599 -> 5,9,9.
  - bin_in=0 -> all zero, blank=8'hFE.
- start held high continuously with bin_in changing each cycle:
  - only the values present on accept edges are converted;
  - done pulses every 11 cycles;
  - outputs are stable between pulses;
  - starts during busy are ignored.
- Back-to-back: assert start with bin_in=500 in the done cycle of a 1000 conversion -> outputs show 1000 (blank=8'hF0) for 11 cycles, then 500 (blank=8'hF8); no idle gap.
- Reset mid-conversion:
  - convert 1000 to completion;
  - start 77, assert rstb=0 at the 4th shift cycle;
  - outputs go to 0 / blank=8'hFE; no done pulse;
  - after release, a fresh start of 77 yields bcd_1=7, bcd_0=7, blank=8'hFC.
